// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and the
// opcode patterns that mark a two-word instruction.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH1 = 2'd1,
    FETCH2 = 2'd2
  } fetch_state_t;

  // Two-word opcodes are identified by mask/match pairs.
  localparam logic [15:0] LDS_MASK   = 16'hFE0F;
  localparam logic [15:0] LDS_MATCH  = 16'h9000;
  localparam logic [15:0] STS_MASK   = 16'hFE0F;
  localparam logic [15:0] STS_MATCH  = 16'h9200;
  localparam logic [15:0] JMP_MASK   = 16'hFE0E;
  localparam logic [15:0] JMP_MATCH  = 16'h940C;
  localparam logic [15:0] CALL_MASK  = 16'hFE0E;
  localparam logic [15:0] CALL_MATCH = 16'h940E;

  function automatic logic is_two_word(input logic [15:0] word);
    return ((word & LDS_MASK)  == LDS_MATCH)  ||
           ((word & STS_MASK)  == STS_MATCH)  ||
           ((word & JMP_MASK)  == JMP_MATCH)  ||
           ((word & CALL_MASK) == CALL_MATCH);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the PC through a synchronous ROM, assembles
// one- or two-word instructions and hands them to decode over valid/ready.
// The ROM registers its output on the falling edge, so rom_data seen at a
// rising edge always belongs to the PC presented during that cycle.
//
//   state  | meaning
//   BOOT   | first cycle after reset; ROM output not yet trustworthy
//   FETCH1 | rom_data holds an opcode word (word0)
//   FETCH2 | rom_data holds the operand word (word1) of a two-word opcode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_two_word
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(1);

  fetch_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [DATA_WIDTH-1:0] word0, word0_nxt;
  logic [ADDR_WIDTH-1:0] word0_pc, word0_pc_nxt;
  logic                  valid_nxt;
  logic [31:0]           instr_nxt;
  logic [ADDR_WIDTH-1:0] instr_pc_nxt;
  logic                  two_word_nxt;

  logic slot_free;
  logic two_word;

  // The output slot can take a new instruction when empty or being consumed.
  assign slot_free = !instr_valid || instr_ready;
  assign two_word  = is_two_word(rom_data);
  assign rom_addr  = pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a redirect always lands in FETCH1, abandoning any half-fetch.
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = FETCH1;
    end else begin
      case (state)
        BOOT:    state_nxt = FETCH1;
        FETCH1:  if (slot_free && two_word) state_nxt = FETCH2;
        FETCH2:  if (slot_free) state_nxt = FETCH1;
        default: state_nxt = BOOT;
      endcase
    end
  end

  // Datapath next values; with the slot blocked everything simply holds.
  always_comb begin
    pc_nxt       = pc;
    word0_nxt    = word0;
    word0_pc_nxt = word0_pc;
    valid_nxt    = instr_valid;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    two_word_nxt = instr_two_word;
    if (redirect_valid) begin
      pc_nxt    = redirect_pc;
      valid_nxt = 1'b0;
      word0_nxt = '0;
    end else if (slot_free) begin
      case (state)
        FETCH1: begin
          pc_nxt = pc + PC_STEP;
          if (two_word) begin
            word0_nxt    = rom_data;
            word0_pc_nxt = pc;
            valid_nxt    = 1'b0;
          end else begin
            instr_nxt    = {rom_data, {DATA_WIDTH{1'b0}}};
            instr_pc_nxt = pc;
            two_word_nxt = 1'b0;
            valid_nxt    = 1'b1;
          end
        end
        FETCH2: begin
          pc_nxt       = pc + PC_STEP;
          instr_nxt    = {word0, rom_data};
          instr_pc_nxt = word0_pc;
          two_word_nxt = 1'b1;
          valid_nxt    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= '0;
      word0          <= '0;
      word0_pc       <= '0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      instr_two_word <= 1'b0;
    end else begin
      pc             <= pc_nxt;
      word0          <= word0_nxt;
      word0_pc       <= word0_pc_nxt;
      instr_valid    <= valid_nxt;
      instr          <= instr_nxt;
      instr_pc       <= instr_pc_nxt;
      instr_two_word <= two_word_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a falling-edge ROM model and a
// scoreboard of expected delivered instructions.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  pc;
    logic        two;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = 16'h0;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_two_word;

  logic [15:0] mem [256];
  logic [15:0] prog [6];
  exp_t        sb [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_two_word (instr_two_word)
  );

  always #5 clk = ~clk;

  // ROM registers the addressed word on the falling edge.
  always @(negedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [7:0] p, input logic t);
    return {i, p, t};
  endfunction

  // Every handshake the next rising edge will complete is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_instr observed pc %0h instr %0h expected none", instr_pc, instr);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sb_instr", instr, mon_e.instr);
        chk("sb_pc", 32'(instr_pc), 32'(mon_e.pc));
        chk("sb_two", 32'(instr_two_word), 32'(mon_e.two));
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    prog[0] = 16'hE80B; prog[1] = 16'hBB09; prog[2] = 16'hE011;
    prog[3] = 16'hBB18; prog[4] = 16'hE027; prog[5] = 16'hBB26;
    for (int i = 0; i < 6; i++) mem[i] = prog[i];
    mem[10]   = 16'h940C; mem[11] = 16'h0020;
    mem[20]   = 16'h940E; mem[21] = 16'h1234;
    mem[8'h40] = 16'hE0AA;
    mem[255]  = 16'h9000;

    rst_n = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h0;
    instr_ready = 1'b1;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_two", 32'(instr_two_word), 32'd0);
    tick(); tick();
    chk("rst_hold_valid", 32'(instr_valid), 32'd0);

    // Timer-0 setup program streamed with ready high.
    for (int i = 0; i < 6; i++) sb.push_back(mk({prog[i], 16'h0}, 8'(i), 1'b0));
    sb.push_back(mk(32'h0, 8'd6, 1'b0));
    sb.push_back(mk(32'h940C0020, 8'd10, 1'b1));
    rst_n = 1'b1;
    tick();
    chk("boot_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("prog_valid", 32'(instr_valid), 32'd1);
      chk("prog_pc", 32'(instr_pc), 32'(i));
    end
    redirect_valid = 1'b1; redirect_pc = 8'd10;

    // JMP at 10: one bubble then a single two-word instruction.
    tick();
    redirect_valid = 1'b0;
    chk("jmp_redir_valid", 32'(instr_valid), 32'd0);
    chk("jmp_rom_addr", 32'(rom_addr), 32'd10);
    tick();
    chk("jmp_bubble", 32'(instr_valid), 32'd0);
    chk("jmp_word1_addr", 32'(rom_addr), 32'd11);
    tick();
    chk("jmp_valid", 32'(instr_valid), 32'd1);
    chk("jmp_two", 32'(instr_two_word), 32'd1);
    for (int i = 0; i < 4; i++) sb.push_back(mk({prog[i], 16'h0}, 8'(i), 1'b0));
    redirect_valid = 1'b1; redirect_pc = 8'd0;

    // Stall three cycles with instr_pc=2.
    tick();
    redirect_valid = 1'b0;
    chk("stall_redir_valid", 32'(instr_valid), 32'd0);
    tick(); chk("stall_pc0", 32'(instr_pc), 32'd0);
    tick(); chk("stall_pc1", 32'(instr_pc), 32'd1);
    tick(); chk("stall_pc2", 32'(instr_pc), 32'd2);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen_valid", 32'(instr_valid), 32'd1);
      chk("frozen_instr", instr, 32'hE0110000);
      chk("frozen_pc", 32'(instr_pc), 32'd2);
      chk("frozen_rom_addr", 32'(rom_addr), 32'd3);
    end
    instr_ready = 1'b1;
    tick();
    chk("release_valid", 32'(instr_valid), 32'd1);
    chk("release_pc", 32'(instr_pc), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 8'd20;

    // CALL at 20 redirected to 0x40 while fetching its second word.
    tick();
    redirect_valid = 1'b0;
    chk("call_valid0", 32'(instr_valid), 32'd0);
    tick();
    chk("call_fetch2_valid", 32'(instr_valid), 32'd0);
    chk("call_fetch2_addr", 32'(rom_addr), 32'd21);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("call_drop_valid", 32'(instr_valid), 32'd0);
    chk("call_drop_addr", 32'(rom_addr), 32'h40);
    sb.push_back(mk(32'hE0AA0000, 8'h40, 1'b0));
    tick();
    chk("target_valid", 32'(instr_valid), 32'd1);
    chk("target_pc", 32'(instr_pc), 32'h40);
    chk("target_two", 32'(instr_two_word), 32'd0);
    mem[0] = 16'h0060;
    sb.push_back(mk(32'h90000060, 8'd255, 1'b1));
    sb.push_back(mk(32'hBB090000, 8'd1, 1'b0));
    redirect_valid = 1'b1; redirect_pc = 8'd255;

    // LDS at 255 wraps to take its operand from address 0.
    tick();
    redirect_valid = 1'b0;
    chk("lds_valid0", 32'(instr_valid), 32'd0);
    chk("lds_addr", 32'(rom_addr), 32'd255);
    tick();
    chk("lds_wrap_addr", 32'(rom_addr), 32'd0);
    chk("lds_bubble", 32'(instr_valid), 32'd0);
    tick();
    chk("lds_valid", 32'(instr_valid), 32'd1);
    chk("lds_instr", instr, 32'h90000060);
    chk("lds_pc", 32'(instr_pc), 32'd255);
    tick();
    chk("after_lds_pc", 32'(instr_pc), 32'd1);
    mem[0] = 16'hE80B;
    redirect_valid = 1'b1; redirect_pc = 8'd20;

    // Half-cycle reset pulse in the middle of a two-word fetch.
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("mid_fetch2_addr", 32'(rom_addr), 32'd21);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_instr_pc", 32'(instr_pc), 32'd0);
    #4 rst_n = 1'b1;
    sb.push_back(mk(32'hE80B0000, 8'd0, 1'b0));
    tick();
    chk("restart_boot_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("restart_valid", 32'(instr_valid), 32'd1);
    chk("restart_pc", 32'(instr_pc), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 8'd0;
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
